// File: rtl/cursor_engine.sv
// cursor_engine: cursor/margin state engine with scroll handshake; optional origin mode via CURSOR_ORIGIN_MODE_EN
module cursor_engine #(
    parameter int COLUMNS = 80,
    parameter int LINES   = 24,
    parameter int W       = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_type,
    input  logic [W-1:0] pn1,
    input  logic [W-1:0] pn2,
    output logic [W-1:0] cursor_row,
    output logic [W-1:0] cursor_col,
    output logic [W-1:0] scroll_top,
    output logic [W-1:0] scroll_bottom,
    output logic         scroll_valid,
    output logic         scroll_dir,
    input  logic         scroll_ready
);
    typedef enum logic {IDLE, SCROLL} state_t;

    localparam logic [W:0] MAX_ROW = (W+1)'(LINES - 1);
    localparam logic [W:0] MAX_COL = (W+1)'(COLUMNS - 1);
    localparam logic [W:0] ONE     = (W+1)'(1);

    localparam logic [3:0] C_CUP = 4'd1, C_CUF = 4'd2, C_CUB = 4'd3, C_CUD = 4'd4,
                           C_CUU = 4'd5, C_IND = 4'd6, C_RI = 4'd7, C_NEL = 4'd8,
                           C_CR = 4'd9, C_STBM = 4'd10, C_SC = 4'd11, C_RC = 4'd12,
                           C_CHA = 4'd13, C_VPA = 4'd14, C_OM = 4'd15;

    state_t state_q, state_d;
    logic [W-1:0] row_q, row_d, col_q, col_d, top_q, top_d, bot_q, bot_d;
    logic [W-1:0] srow_q, srow_d, scol_q, scol_d;
    logic dir_q, dir_d, accept, scroll_go, org;
    logic [W:0] row_w, col_w, top_w, bot_w, n_w, p1_w, p2_w, b_w;
    logic [W:0] abs_row, cup_col, cha_col, cuf_w, cub_w, cud_lim, cud_w, cuu_lim, cuu_w;

`ifdef CURSOR_ORIGIN_MODE_EN
    logic org_q, org_d, sorg_q, sorg_d;
    assign org = org_q;
`else
    assign org = 1'b0;
`endif

    assign cmd_ready     = (state_q == IDLE);
    assign scroll_valid  = (state_q == SCROLL);
    assign accept        = cmd_valid & cmd_ready;
    assign cursor_row    = row_q;
    assign cursor_col    = col_q;
    assign scroll_top    = top_q;
    assign scroll_bottom = bot_q;
    assign scroll_dir    = dir_q;

    // All arithmetic runs one bit wider than the coordinates so nothing wraps before clamping
    assign row_w   = {1'b0, row_q};
    assign col_w   = {1'b0, col_q};
    assign top_w   = {1'b0, top_q};
    assign bot_w   = {1'b0, bot_q};
    assign n_w     = (pn1 == '0) ? ONE : {1'b0, pn1};
    assign p1_w    = (pn1 == '0) ? '0 : {1'b0, pn1} - ONE;
    assign p2_w    = (pn2 == '0) ? '0 : {1'b0, pn2} - ONE;
    assign b_w     = (pn2 == '0 || p2_w > MAX_ROW) ? MAX_ROW : p2_w;
    assign abs_row = org ? ((top_w + p1_w > bot_w) ? bot_w : top_w + p1_w)
                         : ((p1_w > MAX_ROW) ? MAX_ROW : p1_w);
    assign cup_col = (p2_w > MAX_COL) ? MAX_COL : p2_w;
    assign cha_col = (p1_w > MAX_COL) ? MAX_COL : p1_w;
    assign cuf_w   = (col_w + n_w > MAX_COL) ? MAX_COL : col_w + n_w;
    assign cub_w   = (col_w >= n_w) ? col_w - n_w : '0;
    assign cud_lim = (org || row_w <= bot_w) ? bot_w : MAX_ROW;
    assign cud_w   = (row_w + n_w > cud_lim) ? cud_lim : row_w + n_w;
    assign cuu_lim = (org || row_w >= top_w) ? top_w : '0;
    assign cuu_w   = (row_w >= cuu_lim + n_w) ? row_w - n_w : cuu_lim;

    // Command execution: next cursor/margin/saved state and scroll trigger for an accepted command
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        top_d     = top_q;
        bot_d     = bot_q;
        srow_d    = srow_q;
        scol_d    = scol_q;
        dir_d     = dir_q;
        scroll_go = 1'b0;
`ifdef CURSOR_ORIGIN_MODE_EN
        org_d     = org_q;
        sorg_d    = sorg_q;
`endif
        if (accept) begin
            case (cmd_type)
                C_CUP: begin
                    row_d = W'(abs_row);
                    col_d = W'(cup_col);
                end
                C_CUF: col_d = W'(cuf_w);
                C_CUB: col_d = W'(cub_w);
                C_CUD: row_d = W'(cud_w);
                C_CUU: row_d = W'(cuu_w);
                C_IND, C_NEL: begin
                    if (row_q == bot_q) begin
                        scroll_go = 1'b1;
                        dir_d     = 1'b0;
                    end else if (row_w != MAX_ROW) begin
                        row_d = W'(row_w + ONE);
                    end
                    if (cmd_type == C_NEL) col_d = '0;
                end
                C_RI: begin
                    if (row_q == top_q) begin
                        scroll_go = 1'b1;
                        dir_d     = 1'b1;
                    end else if (row_q != '0) begin
                        row_d = W'(row_w - ONE);
                    end
                end
                C_CR: col_d = '0;
                C_STBM: begin
                    if (p1_w < b_w) begin
                        top_d = W'(p1_w);
                        bot_d = W'(b_w);
                        row_d = org ? W'(p1_w) : '0;
                        col_d = '0;
                    end
                end
                C_SC: begin
                    srow_d = row_q;
                    scol_d = col_q;
`ifdef CURSOR_ORIGIN_MODE_EN
                    sorg_d = org_q;
`endif
                end
                C_RC: begin
                    row_d = srow_q;
                    col_d = scol_q;
`ifdef CURSOR_ORIGIN_MODE_EN
                    org_d = sorg_q;
`endif
                end
                C_CHA: col_d = W'(cha_col);
                C_VPA: row_d = W'(abs_row);
`ifdef CURSOR_ORIGIN_MODE_EN
                C_OM: begin
                    org_d = (pn1 != '0);
                    row_d = (pn1 != '0) ? top_q : '0;
                    col_d = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    // Scroll handshake FSM: hold the request until the text buffer takes it
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (scroll_go ? SCROLL : IDLE)
                                    : (scroll_ready ? IDLE : SCROLL);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            top_q   <= '0;
            bot_q   <= W'(MAX_ROW);
            srow_q  <= '0;
            scol_q  <= '0;
            dir_q   <= 1'b0;
`ifdef CURSOR_ORIGIN_MODE_EN
            org_q   <= 1'b0;
            sorg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            srow_q  <= srow_d;
            scol_q  <= scol_d;
            dir_q   <= dir_d;
`ifdef CURSOR_ORIGIN_MODE_EN
            org_q   <= org_d;
            sorg_q  <= sorg_d;
`endif
        end
    end
endmodule

// File: tb/tb_cursor_engine.sv
// tb_cursor_engine: scoreboard bench for cursor_engine against a behavioural cursor model
module tb_cursor_engine;
    localparam int COLS = 80;
    localparam int ROWS = 24;

    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready, scroll_valid, scroll_dir, scroll_ready = 1'b0;
    logic [3:0] cmd_type = '0;
    logic [7:0] pn1 = '0, pn2 = '0;
    logic [7:0] cursor_row, cursor_col, scroll_top, scroll_bottom;

    cursor_engine #(.COLUMNS(COLS), .LINES(ROWS), .W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .pn1(pn1), .pn2(pn2),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .scroll_top(scroll_top), .scroll_bottom(scroll_bottom),
        .scroll_valid(scroll_valid), .scroll_dir(scroll_dir), .scroll_ready(scroll_ready)
    );

    always #5 clk = ~clk;

    typedef struct {int row; int col; int top; int bot; int valid; int dir; int ready;} snap_t;
    snap_t exp_q[$];
    snap_t e;
    int checks = 0, errors = 0;
    bit ev = 1'b0;

    // reference model of the visible console state
    int mrow, mcol, mtop, mbot, srow, scol, mdir, morg, msorg;
    bit mscroll;

    function automatic int min2(int a, int b); return a < b ? a : b; endfunction
    function automatic int max2(int a, int b); return a > b ? a : b; endfunction

    task automatic model_reset();
        mrow = 0; mcol = 0; mtop = 0; mbot = ROWS - 1; srow = 0; scol = 0;
        mdir = 0; morg = 0; msorg = 0; mscroll = 0;
    endtask

    task automatic model_apply(input int t, input int a, input int b);
        int n, p1, p2, lim, tt, bb;
        n  = (a == 0) ? 1 : a;
        p1 = (a == 0) ? 0 : a - 1;
        p2 = (b == 0) ? 0 : b - 1;
        case (t)
            1: begin
                mrow = morg ? min2(mtop + p1, mbot) : min2(p1, ROWS - 1);
                mcol = min2(p2, COLS - 1);
            end
            2: mcol = min2(mcol + n, COLS - 1);
            3: mcol = max2(mcol - n, 0);
            4: begin lim = (morg != 0 || mrow <= mbot) ? mbot : ROWS - 1; mrow = min2(mrow + n, lim); end
            5: begin lim = (morg != 0 || mrow >= mtop) ? mtop : 0; mrow = max2(mrow - n, lim); end
            6, 8: begin
                if (mrow == mbot) begin mscroll = 1; mdir = 0; end
                else if (mrow != ROWS - 1) mrow++;
                if (t == 8) mcol = 0;
            end
            7: begin
                if (mrow == mtop) begin mscroll = 1; mdir = 1; end
                else if (mrow != 0) mrow--;
            end
            9: mcol = 0;
            10: begin
                tt = p1;
                bb = (b == 0) ? ROWS - 1 : min2(b - 1, ROWS - 1);
                if (tt < bb) begin mtop = tt; mbot = bb; mrow = morg ? tt : 0; mcol = 0; end
            end
            11: begin srow = mrow; scol = mcol; msorg = morg; end
            12: begin mrow = srow; mcol = scol; morg = msorg; end
            13: mcol = min2(p1, COLS - 1);
            14: mrow = morg ? min2(mtop + p1, mbot) : min2(p1, ROWS - 1);
`ifdef CURSOR_ORIGIN_MODE_EN
            15: begin morg = (a != 0); mrow = morg ? mtop : 0; mcol = 0; end
`endif
            default: ;
        endcase
    endtask

    task automatic push_snap();
        snap_t s;
        s.row = mrow; s.col = mcol; s.top = mtop; s.bot = mbot;
        s.valid = int'(mscroll); s.dir = mdir; s.ready = int'(!mscroll);
        exp_q.push_back(s);
    endtask

    // drive one cycle of stimulus at the falling edge and record what the model expects after the next rising edge
    task automatic step(input bit v, input int t, input int a, input int b, input bit sr);
        bit acc, hs;
        @(negedge clk);
        rst = 1'b0; cmd_valid = v; cmd_type = 4'(t); pn1 = 8'(a); pn2 = 8'(b); scroll_ready = sr;
        acc = v && !mscroll;
        hs  = mscroll && sr;
        if (hs) mscroll = 0;
        if (acc) model_apply(t, a, b);
        ev = acc || hs || mscroll;
        if (ev) push_snap();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; scroll_ready = 1'b0;
        model_reset();
        ev = 1'b1;
        push_snap();
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, want);
        end
    endtask

    // monitor: whenever an output change is expected, pop the scoreboard and compare the whole visible state
    initial forever begin
        @(posedge clk);
        if (ev) begin
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (int'(cursor_row) != e.row || int'(cursor_col) != e.col || int'(scroll_top) != e.top ||
                    int'(scroll_bottom) != e.bot || int'(scroll_valid) != e.valid ||
                    int'(scroll_dir) != e.dir || int'(cmd_ready) != e.ready) begin
                    errors++;
                    $display("FAIL state at %0t got r=%0d c=%0d t=%0d b=%0d v=%0d d=%0d rdy=%0d expected r=%0d c=%0d t=%0d b=%0d v=%0d d=%0d rdy=%0d",
                             $time, cursor_row, cursor_col, scroll_top, scroll_bottom, scroll_valid, scroll_dir, cmd_ready,
                             e.row, e.col, e.top, e.bot, e.valid, e.dir, e.ready);
                end
            end
        end
    end

    initial begin
        int t, a, b;
        model_reset();
        do_reset(); after_edge();
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_bottom", int'(scroll_bottom), 23);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_valid", int'(scroll_valid), 0);

        step(1, 1, 5, 200, 0); after_edge();
        chk("cup_row", int'(cursor_row), 4);
        chk("cup_col", int'(cursor_col), 79);
        step(1, 1, 11, 79, 0);
        step(1, 2, 0, 0, 0); after_edge();
        chk("cuf_col", int'(cursor_col), 79);
        step(1, 3, 200, 0, 0); after_edge();
        chk("cub_col", int'(cursor_col), 0);
        step(1, 5, 0, 0, 0); after_edge();
        chk("cuu_row", int'(cursor_row), 9);

        step(1, 10, 5, 20, 0); after_edge();
        chk("stbm_top", int'(scroll_top), 4);
        chk("stbm_bot", int'(scroll_bottom), 19);
        chk("stbm_home", int'(cursor_row) + int'(cursor_col), 0);
        step(1, 1, 20, 1, 0);
        step(1, 6, 0, 0, 0); after_edge();
        chk("ind_valid", int'(scroll_valid), 1);
        chk("ind_dir", int'(scroll_dir), 0);
        chk("ind_ready", int'(cmd_ready), 0);
        chk("ind_row", int'(cursor_row), 19);
        repeat (3) step(1, 2, 1, 0, 0);
        after_edge();
        chk("scroll_hold", int'(scroll_valid), 1);
        step(0, 0, 0, 0, 1); after_edge();
        chk("scroll_done", int'(scroll_valid), 0);
        chk("ready_back", int'(cmd_ready), 1);

        step(1, 1, 5, 1, 0);
        step(1, 7, 0, 0, 0); after_edge();
        chk("ri_valid", int'(scroll_valid), 1);
        chk("ri_dir", int'(scroll_dir), 1);
        step(0, 0, 0, 0, 0);
        do_reset(); after_edge();
        chk("rst_scroll_valid", int'(scroll_valid), 0);
        chk("rst_scroll_bot", int'(scroll_bottom), 23);
        chk("rst_scroll_row", int'(cursor_row), 0);

        step(1, 10, 10, 3, 0); after_edge();
        chk("stbm_bad_top", int'(scroll_top), 0);
        chk("stbm_bad_bot", int'(scroll_bottom), 23);
        step(1, 1, 8, 34, 0);
        step(1, 11, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        step(1, 12, 0, 0, 0); after_edge();
        chk("decrc_row", int'(cursor_row), 7);
        chk("decrc_col", int'(cursor_col), 33);

`ifdef CURSOR_ORIGIN_MODE_EN
        step(1, 10, 5, 20, 0);
        step(1, 15, 1, 0, 0); after_edge();
        chk("om_home_row", int'(cursor_row), 4);
        chk("om_home_col", int'(cursor_col), 0);
        step(1, 1, 30, 1, 0); after_edge();
        chk("om_cup_row", int'(cursor_row), 19);
        step(1, 5, 50, 0, 0); after_edge();
        chk("om_cuu_row", int'(cursor_row), 4);
        step(1, 15, 0, 0, 0);
`else
        step(1, 1, 3, 3, 0);
        step(1, 15, 1, 0, 0); after_edge();
        chk("code15_nop_row", int'(cursor_row), 2);
        chk("code15_nop_col", int'(cursor_col), 2);
`endif

        for (int i = 0; i < 800; i++) begin
            t = $urandom_range(0, 15);
            a = ($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 1) != 0 ? $urandom_range(1, 30) : $urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? 0 : ($urandom_range(0, 1) != 0 ? $urandom_range(1, 30) : $urandom_range(0, 255));
            if (i % 200 == 199) do_reset();
            else step($urandom_range(0, 4) != 0, t, a, b, $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        ev = 1'b0; cmd_valid = 1'b0; scroll_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
